// File: rtl/synth_pkg.sv
// Shared constants, voice state and quarter-sine table generator for the synth voice path.
// Define NCO_ENV_EN to add the RELEASE state used by the linear envelope.
package synth_pkg;

    localparam int unsigned PHASE_W     = 32;
    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned LUT_AW      = 8;
    localparam int unsigned LUT_DW      = SAMPLE_W - 1;
    localparam int unsigned NOTE_W      = 7;
    localparam int unsigned ENV_W       = 8;
    localparam int unsigned ROM_LATENCY = 1;

    localparam real HALF_PI = 1.5707963267948966;

    typedef enum logic [2:0] {
        StIdle,
        StFetch0,
        StFetch1,
`ifdef NCO_ENV_EN
        StRun,
        StRelease
`else
        StRun
`endif
    } voice_state_e;

    // Sampled at the centre of each bin so the table never hits exactly 0 or needs a 257th entry.
    function automatic int quarter_sine(input int unsigned idx, input int unsigned aw,
                                        input int unsigned dw);
        real full;
        real x;
        full = $itor((1 << dw) - 1);
        x = full * $sin(HALF_PI * ($itor(idx) + 0.5) / $itor(1 << aw));
        return $rtoi(x + 0.5);
    endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Registered quarter-wave sine table; the caller supplies the already-mirrored index
// and applies the sign itself.
module sine_quarter_lut
    import synth_pkg::*;
#(
    parameter int unsigned AW = LUT_AW,
    parameter int unsigned DW = LUT_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    logic [DW-1:0] rom [2**AW];
    logic [DW-1:0] data_q;

    for (genvar i = 0; i < 2**AW; i++) begin : g_rom
        assign rom[i] = DW'(quarter_sine(i, AW, DW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= rom[addr];
        end
    end

    assign data = data_q;

endmodule

// File: rtl/nco_voice.sv
// Monophonic sine voice: note events drive the step ROM, phase accumulates per sample tick
// and a quarter-wave LUT produces the sample. Optional envelope via NCO_ENV_EN.
module nco_voice
    import synth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  note_i,
    input  logic        note_on_i,
    input  logic        note_off_i,
    input  logic        sample_tick_i,
    output logic [6:0]  rom_addr_o,
    input  logic [31:0] rom_step_i,
    output logic [15:0] sample_o,
    output logic        sample_valid_o,
    output logic        active_o,
    output logic [31:0] phase_o
);

    voice_state_e state_q, state_d;
    logic [NOTE_W-1:0]  cur_note_q, cur_note_d;
    logic [NOTE_W-1:0]  rom_addr_q, rom_addr_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [PHASE_W-1:0] phase_q;
    logic               off_hit;

    logic               tick_d1_q, tick_d2_q;
    logic [1:0]         quad_q;
    logic [LUT_AW-1:0]  lut_addr;
    logic [LUT_DW-1:0]  lut_data;
    logic signed [SAMPLE_W-1:0] lut_signed;
    logic [SAMPLE_W-1:0] sample_d, sample_q;
    logic               sample_valid_q;

`ifdef NCO_ENV_EN
    logic [ENV_W-1:0]   env_q, env_d;
    logic [ENV_W-1:0]   amp;
    logic signed [SAMPLE_W+ENV_W:0] env_prod;
`endif

    // ---------------------------------------------------------------- voice FSM
    always_comb begin
        state_d    = state_q;
        cur_note_d = cur_note_q;
        rom_addr_d = rom_addr_q;
        step_d     = step_q;
        off_hit    = note_off_i && (note_i == cur_note_q) &&
                     (state_q inside {StFetch0, StFetch1, StRun});

        if (note_on_i) begin
            // Legato retrigger: phase is left alone, only the step is refetched.
            cur_note_d = note_i;
            rom_addr_d = note_i;
            state_d    = StFetch0;
        end else begin
            unique case (state_q)
                StFetch0: state_d = StFetch1;
                StFetch1: begin
                    step_d  = rom_step_i;
                    state_d = (rom_step_i == '0) ? StIdle : StRun;
                end
`ifdef NCO_ENV_EN
                StRelease: begin
                    if (sample_tick_i && (env_q <= ENV_W'(1))) begin
                        state_d = StIdle;
                    end
                end
`endif
                default: ;
            endcase

            if (off_hit) begin
`ifdef NCO_ENV_EN
                state_d = StRelease;
`else
                state_d = StIdle;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cur_note_q <= '0;
            rom_addr_q <= '0;
            step_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_note_q <= cur_note_d;
            rom_addr_q <= rom_addr_d;
            step_q     <= step_d;
        end
    end

    // ---------------------------------------------------------------- phase accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else if (sample_tick_i && (state_q != StIdle)) begin
            phase_q <= phase_q + step_q;
        end
    end

`ifdef NCO_ENV_EN
    // ---------------------------------------------------------------- linear envelope
    always_comb begin
        env_d = env_q;
        if (state_q == StIdle) begin
            env_d = '0;
        end else if (sample_tick_i) begin
            if (state_q == StRelease) begin
                env_d = (env_q == '0) ? '0 : env_q - ENV_W'(1);
            end else if (env_q != '1) begin
                env_d = env_q + ENV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_q <= '0;
        end else begin
            env_q <= env_d;
        end
    end
`endif

    // ---------------------------------------------------------------- sample pipeline
    // Odd quadrants run the quarter wave backwards: 255-idx is just the bitwise inverse.
    assign lut_addr = phase_q[30] ? ~phase_q[29:22] : phase_q[29:22];

    sine_quarter_lut #(
        .AW (LUT_AW),
        .DW (LUT_DW)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (lut_addr),
        .data  (lut_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_d1_q <= 1'b0;
            tick_d2_q <= 1'b0;
            quad_q    <= '0;
        end else begin
            tick_d1_q <= sample_tick_i;
            tick_d2_q <= tick_d1_q;
            quad_q    <= phase_q[31:30];
        end
    end

    assign lut_signed = quad_q[1] ? -$signed({1'b0, lut_data}) : $signed({1'b0, lut_data});

`ifdef NCO_ENV_EN
    assign amp      = (state_q == StIdle) ? '0 : env_q;
    assign env_prod = lut_signed * $signed({1'b0, amp});
    assign sample_d = SAMPLE_W'(env_prod >>> ENV_W);
`else
    assign sample_d = (state_q == StIdle) ? '0 : lut_signed;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= tick_d2_q;
            if (tick_d2_q) begin
                sample_q <= sample_d;
            end
        end
    end

    assign rom_addr_o     = rom_addr_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;
    assign active_o       = (state_q != StIdle);
    assign phase_o        = phase_q;

endmodule

// File: tb/tb_nco_voice.sv
// Self-checking bench for nco_voice: directed scenarios plus randomized note/tick traffic
// against a transaction-level voice model.
module tb_nco_voice;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  note_i;
    logic        note_on_i, note_off_i, sample_tick_i;
    logic [6:0]  rom_addr_o;
    logic [31:0] rom_step_i;
    logic [15:0] sample_o;
    logic        sample_valid_o, active_o;
    logic [31:0] phase_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rom_table [128];
    logic [31:0] m_phase, m_step;
    logic        m_active;
    logic [6:0]  m_note;

`ifdef NCO_ENV_EN
    localparam bit ENV = 1'b1;
`else
    localparam bit ENV = 1'b0;
`endif

    always #5 clk = ~clk;

    // Step ROM: registered, data valid one cycle after the address changes.
    always @(posedge clk) rom_step_i <= rom_table[rom_addr_o];

    nco_voice dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .note_i         (note_i),
        .note_on_i      (note_on_i),
        .note_off_i     (note_off_i),
        .sample_tick_i  (sample_tick_i),
        .rom_addr_o     (rom_addr_o),
        .rom_step_i     (rom_step_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .active_o       (active_o),
        .phase_o        (phase_o)
    );

    function automatic logic [15:0] ref_sine(input logic [31:0] ph);
        int q, idx, k, mag;
        real a;
        q   = int'(ph[31:30]);
        idx = int'(ph[29:22]);
        k   = (q % 2 == 1) ? 255 - idx : idx;
        a   = $sin(3.14159265358979323846 / 2.0 * ($itor(k) + 0.5) / 256.0);
        mag = $rtoi(32767.0 * a + 0.5);
        return (q >= 2) ? 16'(-mag) : 16'(mag);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic on, input logic off, input logic [6:0] n);
        note_i = n; note_on_i = on; note_off_i = off;
        cyc();
        note_on_i = 1'b0; note_off_i = 1'b0;
    endtask

    // Returns phase in T+1, valid in T+2, valid and sample in T+3.
    task automatic tick(output logic [31:0] ph, output logic v2, output logic v3,
                        output logic [15:0] smp);
        sample_tick_i = 1'b1;
        cyc();
        sample_tick_i = 1'b0;
        ph = phase_o;
        cyc();
        v2 = sample_valid_o;
        cyc();
        v3  = sample_valid_o;
        smp = sample_o;
        cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        m_phase = '0; m_step = '0; m_active = 1'b0; m_note = '0;
    endtask

    task automatic test_reset();
        logic [31:0] ph; logic v2, v3; logic [15:0] smp;
        rst_n = 1'b0;
        cyc(); cyc();
        n_checks++;
        if ({phase_o, sample_o, sample_valid_o, active_o, rom_addr_o} !== '0)
            $display("FAIL reset_outputs got ph=%0h s=%0h v=%0b a=%0b addr=%0h want all 0",
                     phase_o, sample_o, sample_valid_o, active_o, rom_addr_o);
        else n_pass++;
        rst_n = 1'b1;
        cyc();
        m_phase = '0; m_step = '0; m_active = 1'b0; m_note = '0;
        tick(ph, v2, v3, smp);
        n_checks++;
        if ({ph, v2, v3, smp, active_o} !== {32'h0, 1'b0, 1'b1, 16'h0, 1'b0})
            $display("FAIL idle_tick got ph=%0h v2=%0b v3=%0b s=%0h a=%0b want 0 0 1 0 0",
                     ph, v2, v3, smp, active_o);
        else n_pass++;
    endtask

    task automatic test_fetch();
        logic [31:0] ph; logic v2, v3; logic [15:0] smp;
        pulse(1'b1, 1'b0, 7'd69);
        n_checks++;
        if (rom_addr_o !== 7'd69 || active_o !== 1'b1)
            $display("FAIL fetch_addr got addr=%0d a=%0b want 69 1", rom_addr_o, active_o);
        else n_pass++;
        cyc(); cyc();
        tick(ph, v2, v3, smp);
        n_checks++;
        if (ph !== 32'd1999899)
            $display("FAIL fetch_phase got %0d want 1999899", ph);
        else n_pass++;
        n_checks++;
        if (v2 !== 1'b0 || v3 !== 1'b1)
            $display("FAIL sample_latency got v2=%0b v3=%0b want 0 1", v2, v3);
        else n_pass++;
`ifndef NCO_ENV_EN
        n_checks++;
        if (smp !== ref_sine(32'd1999899))
            $display("FAIL fetch_sample got %0h want %0h", smp, ref_sine(32'd1999899));
        else n_pass++;
`endif
        m_phase = 32'd1999899; m_step = 32'd1999899; m_active = 1'b1; m_note = 7'd69;
    endtask

    task automatic test_sine_points();
        logic [31:0] ph; logic v2, v3; logic [15:0] smp;
        logic [15:0] exp_s [4];
        exp_s[0] = 16'h7FFF; exp_s[1] = 16'hFF9B; exp_s[2] = 16'h8001; exp_s[3] = 16'h0065;
        do_reset();
        rom_table[10] = 32'h4000_0000;
        pulse(1'b1, 1'b0, 7'd10);
        cyc(); cyc();
        for (int k = 0; k < 4; k++) begin
            tick(ph, v2, v3, smp);
            n_checks++;
            if (ph !== 32'(k + 1) * 32'h4000_0000 || smp !== exp_s[k] || v3 !== 1'b1)
                $display("FAIL sine_point%0d got ph=%0h s=%0h v=%0b want ph=%0h s=%0h v=1",
                         k, ph, smp, v3, 32'(k + 1) * 32'h4000_0000, exp_s[k]);
            else n_pass++;
        end
        m_phase = '0; m_step = 32'h4000_0000; m_active = 1'b1; m_note = 7'd10;
    endtask

    task automatic test_invalid_note();
        logic [31:0] ph; logic v2, v3; logic [15:0] smp;
        pulse(1'b1, 1'b0, 7'd0);
        n_checks++;
        if (rom_addr_o !== 7'd0 || active_o !== 1'b1)
            $display("FAIL invalid_fetch got addr=%0d a=%0b want 0 1", rom_addr_o, active_o);
        else n_pass++;
        cyc(); cyc();
        n_checks++;
        if (active_o !== 1'b0)
            $display("FAIL invalid_idle got a=%0b want 0", active_o);
        else n_pass++;
        tick(ph, v2, v3, smp);
        n_checks++;
        if (ph !== m_phase || smp !== 16'h0 || v3 !== 1'b1)
            $display("FAIL invalid_hold got ph=%0h s=%0h v=%0b want ph=%0h s=0 v=1",
                     ph, smp, v3, m_phase);
        else n_pass++;
        m_active = 1'b0; m_step = '0; m_note = 7'd0;
    endtask

    task automatic test_note_off();
        logic [31:0] ph; logic v2, v3; logic [15:0] smp;
        pulse(1'b1, 1'b0, 7'd60);
        cyc(); cyc();
        m_step = rom_table[60]; m_active = 1'b1; m_note = 7'd60;
        pulse(1'b0, 1'b1, 7'd61);
        n_checks++;
        if (active_o !== 1'b1)
            $display("FAIL off_mismatch got a=%0b want 1", active_o);
        else n_pass++;
        tick(ph, v2, v3, smp);
        m_phase = m_phase + m_step;
        n_checks++;
        if (ph !== m_phase)
            $display("FAIL off_mismatch_phase got %0h want %0h", ph, m_phase);
        else n_pass++;
        pulse(1'b0, 1'b1, 7'd60);
        n_checks++;
        if (active_o !== ENV)
            $display("FAIL off_match got a=%0b want %0b", active_o, ENV);
        else n_pass++;
`ifndef NCO_ENV_EN
        tick(ph, v2, v3, smp);
        n_checks++;
        if (ph !== m_phase || smp !== 16'h0)
            $display("FAIL off_idle got ph=%0h s=%0h want ph=%0h s=0", ph, smp, m_phase);
        else n_pass++;
`endif
        pulse(1'b1, 1'b1, 7'd62);
        n_checks++;
        if (rom_addr_o !== 7'd62 || active_o !== 1'b1)
            $display("FAIL on_off_same got addr=%0d a=%0b want 62 1", rom_addr_o, active_o);
        else n_pass++;
        cyc(); cyc();
        tick(ph, v2, v3, smp);
        m_step = rom_table[62]; m_phase = m_phase + m_step; m_note = 7'd62;
        n_checks++;
        if (ph !== m_phase || active_o !== 1'b1)
            $display("FAIL on_wins_phase got ph=%0h a=%0b want ph=%0h a=1",
                     ph, active_o, m_phase);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ph; logic v2, v3; logic [15:0] smp;
        pulse(1'b1, 1'b0, 7'd40);
        pulse(1'b1, 1'b0, 7'd50);
        n_checks++;
        if (rom_addr_o !== 7'd50)
            $display("FAIL refetch_addr got %0d want 50", rom_addr_o);
        else n_pass++;
        cyc(); cyc();
        tick(ph, v2, v3, smp);
        m_step = rom_table[50]; m_phase = m_phase + m_step;
        n_checks++;
        if (ph !== m_phase)
            $display("FAIL refetch_phase got %0h want %0h", ph, m_phase);
        else n_pass++;
        // Tick coinciding with a note-on still uses the old step.
        note_i = 7'd30; note_on_i = 1'b1; sample_tick_i = 1'b1;
        cyc();
        note_on_i = 1'b0; sample_tick_i = 1'b0;
        m_phase = m_phase + m_step;
        n_checks++;
        if (phase_o !== m_phase || rom_addr_o !== 7'd30)
            $display("FAIL fetch_old_step got ph=%0h addr=%0d want ph=%0h addr=30",
                     phase_o, rom_addr_o, m_phase);
        else n_pass++;
        cyc(); cyc(); cyc();
        tick(ph, v2, v3, smp);
        m_step = rom_table[30]; m_phase = m_phase + m_step; m_note = 7'd30;
        n_checks++;
        if (ph !== m_phase)
            $display("FAIL new_step_phase got %0h want %0h", ph, m_phase);
        else n_pass++;
    endtask

`ifndef NCO_ENV_EN
    task automatic test_random();
        logic [31:0] ph; logic v2, v3; logic [15:0] smp;
        logic [15:0] exp_s;
        int op, n;
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                n = int'($urandom_range(0, 100));
                if (op >= 3 && op <= 4 && $urandom_range(0, 1) == 1) n = int'(m_note);
                pulse(op <= 2 || op == 5, op >= 3, 7'(n));
                if (op <= 2 || op == 5) begin
                    m_note = 7'(n); m_step = rom_table[n]; m_active = (m_step != 0);
                end else if (m_active && 7'(n) == m_note) begin
                    m_active = 1'b0;
                end
                cyc(); cyc();
                n_checks++;
                if (active_o !== m_active)
                    $display("FAIL rnd_active it=%0d got %0b want %0b", it, active_o, m_active);
                else n_pass++;
            end else begin
                for (int t = 0; t < int'($urandom_range(1, 3)); t++) begin
                    tick(ph, v2, v3, smp);
                    if (m_active) m_phase = m_phase + m_step;
                    exp_s = m_active ? ref_sine(m_phase) : 16'h0;
                    n_checks++;
                    if (ph !== m_phase || smp !== exp_s || v3 !== 1'b1 || v2 !== 1'b0)
                        $display("FAIL rnd_tick it=%0d got ph=%0h s=%0h v=%0b%0b want ph=%0h s=%0h v=01",
                                 it, ph, smp, v2, v3, m_phase, exp_s);
                    else n_pass++;
                end
            end
        end
    endtask
`endif

`ifdef NCO_ENV_EN
    task automatic test_envelope();
        logic [31:0] ph; logic v2, v3; logic [15:0] smp;
        int amp, sv, e, ticks;
        do_reset();
        rom_table[20] = 32'h4000_0000;
        pulse(1'b1, 1'b0, 7'd20);
        cyc(); cyc();
        for (int k = 1; k <= 300; k++) begin
            tick(ph, v2, v3, smp);
            amp = (k < 255) ? k : 255;
            sv  = int'($signed(ref_sine(ph)));
            e   = (sv * amp) >>> 8;
            n_checks++;
            if (smp !== 16'(e))
                $display("FAIL env_attack k=%0d got %0h want %0h", k, smp, 16'(e));
            else n_pass++;
        end
        pulse(1'b0, 1'b1, 7'd20);
        ticks = 0;
        while (active_o === 1'b1 && ticks < 300) begin
            tick(ph, v2, v3, smp);
            ticks++;
            amp = 255 - ticks;
            if (amp < 0) amp = 0;
            sv  = int'($signed(ref_sine(ph)));
            e   = (sv * amp) >>> 8;
            n_checks++;
            if (smp !== 16'(e))
                $display("FAIL env_release k=%0d got %0h want %0h", ticks, smp, 16'(e));
            else n_pass++;
        end
        n_checks++;
        if (ticks != 255 || active_o !== 1'b0)
            $display("FAIL env_release_len got %0d ticks a=%0b want 255 0", ticks, active_o);
        else n_pass++;
        m_phase = phase_o; m_active = 1'b0; m_note = 7'd20; m_step = 32'h4000_0000;
    endtask
`endif

    task automatic test_reset_mid_run();
        logic [31:0] ph; logic v2, v3; logic [15:0] smp;
        logic seen;
        pulse(1'b1, 1'b0, 7'd69);
        cyc(); cyc();
        tick(ph, v2, v3, smp);
        sample_tick_i = 1'b1;
        cyc();
        sample_tick_i = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({phase_o, sample_o, sample_valid_o, active_o, rom_addr_o} !== '0)
            $display("FAIL async_reset got ph=%0h s=%0h v=%0b a=%0b addr=%0h want all 0",
                     phase_o, sample_o, sample_valid_o, active_o, rom_addr_o);
        else n_pass++;
        cyc(); cyc();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (sample_valid_o === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0)
            $display("FAIL inflight_dropped got valid=%0b want 0", seen);
        else n_pass++;
        tick(ph, v2, v3, smp);
        n_checks++;
        if ({ph, v3, smp, active_o} !== {32'h0, 1'b1, 16'h0, 1'b0})
            $display("FAIL post_reset_tick got ph=%0h v=%0b s=%0h a=%0b want 0 1 0 0",
                     ph, v3, smp, active_o);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; note_i = '0; note_on_i = 1'b0; note_off_i = 1'b0; sample_tick_i = 1'b0;
        for (int i = 0; i < 128; i++)
            rom_table[i] = (i >= 1 && i <= 88) ? ($urandom | 32'h1) : 32'h0;
        rom_table[69] = 32'd1999899;

        test_reset();
        test_fetch();
`ifndef NCO_ENV_EN
        test_sine_points();
`endif
        test_invalid_note();
        test_note_off();
        test_back_to_back();
`ifndef NCO_ENV_EN
        test_random();
`else
        test_envelope();
`endif
        test_reset_mid_run();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
